// File: rtl/my_voice_axil_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : my_voice_axil_slave_if
//  Description : AXI4-Lite bus bundle with master and slave views, used by
//                the tone-generator register block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface my_voice_axil_slave_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
);
   // write address channel
   logic [C_S_AXI_ADDR_WIDTH-1:0]     AWADDR;
   logic [2:0]                        AWPROT;
   logic                              AWVALID;
   logic                              AWREADY;
   // write data channel
   logic [C_S_AXI_DATA_WIDTH-1:0]     WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0]   WSTRB;
   logic                              WVALID;
   logic                              WREADY;
   // write response channel
   logic [1:0]                        BRESP;
   logic                              BVALID;
   logic                              BREADY;
   // read address channel
   logic [C_S_AXI_ADDR_WIDTH-1:0]     ARADDR;
   logic [2:0]                        ARPROT;
   logic                              ARVALID;
   logic                              ARREADY;
   // read data channel
   logic [C_S_AXI_DATA_WIDTH-1:0]     RDATA;
   logic [1:0]                        RRESP;
   logic                              RVALID;
   logic                              RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, input AWREADY,
      output WDATA, WSTRB, WVALID, input WREADY,
      input BRESP, BVALID, output BREADY,
      output ARADDR, ARPROT, ARVALID, input ARREADY,
      input RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      input AWADDR, AWPROT, AWVALID, output AWREADY,
      input WDATA, WSTRB, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input ARADDR, ARPROT, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );
endinterface
`default_nettype wire

// File: rtl/my_voice_axil_slave.sv
`default_nettype none
// ============================================================================
//  Module      : my_voice_axil_slave
//  Description : AXI4-Lite slave with four 32-bit control registers driving a
//                square-wave tone generator (reg0[0] enable, reg1[15:0] half
//                period in clock cycles, reg2/reg3 scratch storage).
//  Revision    : 1.0 - initial release
// ============================================================================
module my_voice_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  wire logic                          ACLK,
   input  wire logic                          ARESET,
   my_voice_axil_slave_if.slave               s_axi,
   output logic                               voice_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      ctrl_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      ctrl_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      ctrl_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      ctrl_reg3
);

   localparam int c_NUM_REGS = 4;
   localparam int c_STRB_W   = C_S_AXI_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      WR_IDLE      = 2'd0,
      WR_HAVE_ADDR = 2'd1,
      WR_HAVE_DATA = 2'd2,
      WR_RESP      = 2'd3
   } wr_state_t;

   wr_state_t                       r_wr_state;
   wr_state_t                       w_wr_state_next;

   logic [1:0]                      r_aw_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
   logic [c_STRB_W-1:0]             r_wstrb;

   logic [C_S_AXI_DATA_WIDTH-1:0]   r_regs [c_NUM_REGS];

   logic                            r_rvalid;
   logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;

   logic [15:0]                     r_tone_cnt;
   logic                            r_voice;

   logic                            w_awready;
   logic                            w_wready;
   logic                            w_aw_hs;
   logic                            w_w_hs;
   logic                            w_ar_hs;
   logic                            w_commit;
   logic [1:0]                      w_commit_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]   w_commit_data;
   logic [c_STRB_W-1:0]             w_commit_strb;
   logic [15:0]                     w_half_period;
   logic                            w_tone_en;
   logic                            w_unused;

   // Ready signals depend only on the registered state, so no combinational
   // path exists from VALID to READY.
   assign w_awready = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_DATA);
   assign w_wready  = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_ADDR);
   assign w_aw_hs   = s_axi.AWVALID && w_awready;
   assign w_w_hs    = s_axi.WVALID  && w_wready;
   assign w_ar_hs   = s_axi.ARVALID && !r_rvalid;

   assign s_axi.AWREADY = w_awready;
   assign s_axi.WREADY  = w_wready;
   assign s_axi.BVALID  = (r_wr_state == WR_RESP);
   assign s_axi.BRESP   = 2'b00;
   assign s_axi.ARREADY = !r_rvalid;
   assign s_axi.RVALID  = r_rvalid;
   assign s_axi.RDATA   = r_rdata;
   assign s_axi.RRESP   = 2'b00;

   // Protection bits and byte-offset address bits carry no meaning here.
   assign w_unused = ^{s_axi.AWPROT, s_axi.ARPROT,
                       s_axi.AWADDR[1:0], s_axi.ARADDR[1:0]};

   // Write-channel state register.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_state <= WR_IDLE;
      end else begin
         r_wr_state <= w_wr_state_next;
      end
   end

   // Write-channel next state plus selection of the address/data/strobes to
   // commit, taking whichever half arrives now and the held copy of the other.
   always_comb begin
      w_wr_state_next = r_wr_state;
      w_commit        = 1'b0;
      w_commit_idx    = r_aw_idx;
      w_commit_data   = r_wdata;
      w_commit_strb   = r_wstrb;
      case (r_wr_state)
         WR_IDLE: begin
            if (w_aw_hs && w_w_hs) begin
               w_wr_state_next = WR_RESP;
               w_commit        = 1'b1;
               w_commit_idx    = s_axi.AWADDR[3:2];
               w_commit_data   = s_axi.WDATA;
               w_commit_strb   = s_axi.WSTRB;
            end else if (w_aw_hs) begin
               w_wr_state_next = WR_HAVE_ADDR;
            end else if (w_w_hs) begin
               w_wr_state_next = WR_HAVE_DATA;
            end
         end
         WR_HAVE_ADDR: begin
            if (w_w_hs) begin
               w_wr_state_next = WR_RESP;
               w_commit        = 1'b1;
               w_commit_data   = s_axi.WDATA;
               w_commit_strb   = s_axi.WSTRB;
            end
         end
         WR_HAVE_DATA: begin
            if (w_aw_hs) begin
               w_wr_state_next = WR_RESP;
               w_commit        = 1'b1;
               w_commit_idx    = s_axi.AWADDR[3:2];
            end
         end
         WR_RESP: begin
            if (s_axi.BREADY) begin
               w_wr_state_next = WR_IDLE;
            end
         end
         default: begin
            w_wr_state_next = WR_IDLE;
         end
      endcase
   end

   // Hold the address and data halves as each handshake completes.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_aw_idx <= 2'd0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
      end else begin
         if (w_aw_hs) begin
            r_aw_idx <= s_axi.AWADDR[3:2];
         end
         if (w_w_hs) begin
            r_wdata <= s_axi.WDATA;
            r_wstrb <= s_axi.WSTRB;
         end
      end
   end

   // Register file with byte-lane write enables.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < c_NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_commit) begin
         for (int b = 0; b < c_STRB_W; b++) begin
            if (w_commit_strb[b]) begin
               r_regs[w_commit_idx][b*8 +: 8] <= w_commit_data[b*8 +: 8];
            end
         end
      end
   end

   // Read channel: register the addressed value one cycle after the address
   // handshake; a same-edge write is not yet visible so the old value returns.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (w_ar_hs) begin
         r_rvalid <= 1'b1;
         r_rdata  <= r_regs[s_axi.ARADDR[3:2]];
      end else if (r_rvalid && s_axi.RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign w_half_period = r_regs[1][15:0];
   assign w_tone_en     = r_regs[0][0] && (w_half_period != 16'd0);

   // Tone generator: toggle the output every w_half_period cycles; a new
   // half period restarts the count without disturbing the output level.
   always_ff @(posedge ACLK) begin
      if (ARESET || !w_tone_en) begin
         r_tone_cnt <= 16'd0;
         r_voice    <= 1'b0;
      end else if (w_commit && (w_commit_idx == 2'd1)) begin
         r_tone_cnt <= 16'd0;
      end else if (r_tone_cnt == (w_half_period - 16'd1)) begin
         r_tone_cnt <= 16'd0;
         r_voice    <= !r_voice;
      end else begin
         r_tone_cnt <= r_tone_cnt + 16'd1;
      end
   end

   assign voice_out = r_voice;
   assign ctrl_reg0 = r_regs[0];
   assign ctrl_reg1 = r_regs[1];
   assign ctrl_reg2 = r_regs[2];
   assign ctrl_reg3 = r_regs[3];

endmodule
`default_nettype wire
